// File: rtl/tank_pkg.sv
// Shared types for the tank level controller: per-channel FSM states and
// fault codes. Imported by tank_ch and tank_level_ctrl.
package tank_pkg;

   // Width of one tank's fault_code field on the top-level bus.
   localparam int CODE_W = 2;

   // Per-channel controller state.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FILL  = 2'b01,
      FAULT = 2'b10
   } tank_state_t;

   // Fault cause reported while a channel sits in FAULT. 2'b11 is reserved.
   typedef enum logic [CODE_W-1:0] {
      NONE    = 2'b00,
      SENSOR  = 2'b01,
      TIMEOUT = 2'b10
   } fault_code_t;

endpackage : tank_pkg

// File: rtl/tank_ch.sv
// One tank channel: probe sample register, thermometer decode, IDLE/FILL/FAULT
// hysteresis FSM and, when TANK_TIMEOUT_EN is defined, a fill watchdog timer.
// Reset is asynchronous and active-high; the valve closes the moment reset
// asserts because every output is decoded from the reset-cleared state.
import tank_pkg::*;

module tank_ch #(
   parameter int LVL_W       = 3,
   parameter int LOW_LVL     = 1,
   parameter int HIGH_LVL    = 3,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [LVL_W-1:0]  lvl,
   input  logic              clr_fault,
   output logic              valve,
   output logic              fault,
   output logic [1:0]        fault_code
);

   // Wide enough to count every probe being wet.
   localparam int LEVEL_W = $clog2(LVL_W + 1);
   localparam logic [LEVEL_W-1:0] LOW_L  = LEVEL_W'(LOW_LVL);
   localparam logic [LEVEL_W-1:0] HIGH_L = LEVEL_W'(HIGH_LVL);

   logic [LVL_W-1:0]   lvl_q;
   logic               smp_vld_q;
   logic [LEVEL_W-1:0] level;
   logic               invalid;
   logic               timeout_hit;
   tank_state_t        state_q, next_state;
   fault_code_t        code_q, next_code;

   // Probe sample register; smp_vld_q blocks decisions until a real sample
   // has replaced the reset-cleared value, so a released reset never acts
   // on the all-dry zero it leaves behind.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lvl_q     <= '0;
         smp_vld_q <= 1'b0;
      end else begin
         lvl_q     <= lvl;
         smp_vld_q <= 1'b1;
      end
   end

   // Decode the registered probes: count wet probes, and flag any wet probe
   // sitting above a dry one (a broken thermometer code).
   // NOTE: every combinational output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      level   = '0;
      invalid = 1'b0;
      for (int j = 0; j < LVL_W; j++) begin
         level = level + LEVEL_W'(lvl_q[j]);
      end
      for (int j = 1; j < LVL_W; j++) begin
         if (lvl_q[j] && !lvl_q[j-1]) invalid = 1'b1;
      end
   end

`ifdef TANK_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q;

   // Fill watchdog: zero outside FILL, so it starts from zero on every entry,
   // and advances once per FILL cycle. FILL always exits at CNT_LAST, so the
   // counter can never run past TIMEOUT_CYC.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (state_q == FILL) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end else begin
         cnt_q <= '0;
      end
   end

   assign timeout_hit = (state_q == FILL) && (cnt_q == CNT_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   // State and fault-code register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         code_q  <= NONE;
      end else begin
         state_q <= next_state;
         code_q  <= next_code;
      end
   end

   // Next-state logic: a broken probe code overrides everything, then the
   // watchdog, then the level hysteresis between LOW_LVL and HIGH_LVL.
   always_comb begin
      next_state = state_q;
      next_code  = code_q;
      if (smp_vld_q) begin
         if (invalid) begin
            next_state = FAULT;
            next_code  = SENSOR;
         end else begin
            case (state_q)
               IDLE: begin
                  if (level <= LOW_L) next_state = FILL;
               end
               FILL: begin
                  if (timeout_hit) begin
                     next_state = FAULT;
                     next_code  = TIMEOUT;
                  end else if (level >= HIGH_L) begin
                     next_state = IDLE;
                  end
               end
               FAULT: begin
                  if (clr_fault) begin
                     next_state = IDLE;
                     next_code  = NONE;
                  end
               end
               default: begin
                  next_state = IDLE;
                  next_code  = NONE;
               end
            endcase
         end
      end
   end

   // Outputs decoded purely from the registered state.
   always_comb begin
      valve      = (state_q == FILL);
      fault      = (state_q == FAULT);
      fault_code = (state_q == FAULT) ? code_q : NONE;
   end

endmodule : tank_ch

// File: rtl/tank_level_ctrl.sv
// Multi-tank level controller: NUM_TANKS independent tank_ch channels plus a
// combinational OR of their fault flags. Optional fill watchdog is enabled by
// defining the macro TANK_TIMEOUT_EN (default build: disabled).
import tank_pkg::*;

module tank_level_ctrl #(
   parameter int NUM_TANKS   = 2,
   parameter int LVL_W       = 3,
   parameter int LOW_LVL     = 1,
   parameter int HIGH_LVL    = 3,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_TANKS*LVL_W-1:0]   lvl,
   input  logic [NUM_TANKS-1:0]         clr_fault,
   output logic [NUM_TANKS-1:0]         valve,
   output logic [NUM_TANKS-1:0]         fault,
   output logic [CODE_W*NUM_TANKS-1:0]  fault_code,
   output logic                         any_fault
);

   for (genvar i = 0; i < NUM_TANKS; i++) begin : g_tank
      tank_ch #(
         .LVL_W       (LVL_W),
         .LOW_LVL     (LOW_LVL),
         .HIGH_LVL    (HIGH_LVL),
         .TIMEOUT_CYC (TIMEOUT_CYC)
      ) u_ch (
         .clk        (clk),
         .reset      (reset),
         .lvl        (lvl[i*LVL_W +: LVL_W]),
         .clr_fault  (clr_fault[i]),
         .valve      (valve[i]),
         .fault      (fault[i]),
         .fault_code (fault_code[CODE_W*i +: CODE_W])
      );
   end

   // Summary alarm follows the fault flags in the same cycle.
   assign any_fault = |fault;

endmodule : tank_level_ctrl

// File: tb/tb_tank_level_ctrl.sv
// Self-checking bench for tank_level_ctrl (2 tanks, 3 probes, LOW=1, HIGH=3,
// TIMEOUT_CYC=16). Per-cycle vector table with a two-deep scoreboard queue,
// then hand-written sequences for the watchdog and asynchronous reset.
module tb_tank_level_ctrl;

   localparam int NUM_TANKS   = 2;
   localparam int LVL_W       = 3;
   localparam int TIMEOUT_CYC = 16;

   logic                        clk;
   logic                        reset;
   logic [NUM_TANKS*LVL_W-1:0]  lvl;
   logic [NUM_TANKS-1:0]        clr_fault;
   logic [NUM_TANKS-1:0]        valve;
   logic [NUM_TANKS-1:0]        fault;
   logic [2*NUM_TANKS-1:0]      fault_code;
   logic                        any_fault;

   tank_level_ctrl #(
      .NUM_TANKS   (NUM_TANKS),
      .LVL_W       (LVL_W),
      .LOW_LVL     (1),
      .HIGH_LVL    (3),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .lvl        (lvl),
      .clr_fault  (clr_fault),
      .valve      (valve),
      .fault      (fault),
      .fault_code (fault_code),
      .any_fault  (any_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] lvl;     // {tank1, tank0}
      logic [1:0] clr;
      logic [1:0] valve;   // expected two edges after drive
      logic [1:0] fault;
      logic [3:0] code;    // {code1, code0}
   } vec_t;

   typedef struct {
      int         idx;
      logic [1:0] valve;
      logic [1:0] fault;
      logic [3:0] code;
   } exp_t;

   vec_t vecs [17];
   exp_t sb_q [$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag, input logic [1:0] e_valve,
                                input logic [1:0] e_fault, input logic [3:0] e_code);
      check({tag, ".valve"},      32'(valve),      32'(e_valve));
      check({tag, ".fault"},      32'(fault),      32'(e_fault));
      check({tag, ".fault_code"}, 32'(fault_code), 32'(e_code));
      check({tag, ".any_fault"},  32'(any_fault),  32'(|e_fault));
   endtask

   task automatic pop_compare();
      exp_t e;
      e = sb_q.pop_front();
      check_outputs($sformatf("vec%0d", e.idx), e.valve, e.fault, e.code);
   endtask

   task automatic do_reset(input logic [5:0] rst_lvl);
      reset     = 1'b1;
      lvl       = rst_lvl;
      clr_fault = '0;
      repeat (3) @(negedge clk);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : main
      int hit;
      int bad;
      exp_t e;

      //           lvl1/lvl0     clr    valve  fault  code
      vecs[0]  = '{6'b111_000, 2'b00, 2'b01, 2'b00, 4'b0000};
      vecs[1]  = '{6'b111_001, 2'b00, 2'b01, 2'b00, 4'b0000};
      vecs[2]  = '{6'b111_011, 2'b00, 2'b01, 2'b00, 4'b0000};
      vecs[3]  = '{6'b111_111, 2'b00, 2'b00, 2'b00, 4'b0000};
      vecs[4]  = '{6'b111_011, 2'b00, 2'b00, 2'b00, 4'b0000};
      vecs[5]  = '{6'b111_001, 2'b00, 2'b01, 2'b00, 4'b0000};
      vecs[6]  = '{6'b101_001, 2'b00, 2'b01, 2'b10, 4'b0100};
      vecs[7]  = '{6'b101_001, 2'b10, 2'b01, 2'b10, 4'b0100};
      vecs[8]  = '{6'b011_001, 2'b10, 2'b01, 2'b00, 4'b0000};
      vecs[9]  = '{6'b011_001, 2'b10, 2'b01, 2'b00, 4'b0000};
      vecs[10] = '{6'b011_001, 2'b00, 2'b01, 2'b00, 4'b0000};
      vecs[11] = '{6'b011_111, 2'b00, 2'b00, 2'b00, 4'b0000};
      vecs[12] = '{6'b110_111, 2'b01, 2'b00, 2'b10, 4'b0100};
      vecs[13] = '{6'b000_111, 2'b00, 2'b00, 2'b10, 4'b0100};
      vecs[14] = '{6'b000_111, 2'b00, 2'b00, 2'b00, 4'b0000};
      vecs[15] = '{6'b000_111, 2'b10, 2'b10, 2'b00, 4'b0000};
      vecs[16] = '{6'b000_111, 2'b00, 2'b10, 2'b00, 4'b0000};

      // Reset state.
      do_reset(vecs[0].lvl);
      check_outputs("reset", 2'b00, 2'b00, 4'b0000);

      // Table run: drive on the falling edge, expected result two edges later.
      for (int i = 0; i < 17; i++) begin
         if (i > 0) begin
            @(negedge clk);
            if (sb_q.size() >= 2) pop_compare();
         end
         if (i == 0) reset = 1'b0;
         lvl       = vecs[i].lvl;
         clr_fault = vecs[i].clr;
         e.idx   = i;
         e.valve = vecs[i].valve;
         e.fault = vecs[i].fault;
         e.code  = vecs[i].code;
         sb_q.push_back(e);
      end
      while (sb_q.size() > 0) begin
         @(negedge clk);
         pop_compare();
      end

      // Watchdog: tank0 held at one probe wet, tank1 full and idle.
      do_reset(6'b111_001);
      reset = 1'b0;
      hit = 0;
      bad = 0;
`ifdef TANK_TIMEOUT_EN
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 17) check("valve_before_timeout", 32'(valve[0]), 32'd1);
         if (fault[0] === 1'b1) begin
            hit = k;
            break;
         end
      end
      // FILL entered at edge 2, 16 FILL cycles, FAULT at edge 18.
      check("timeout_edge", hit, 32'd18);
      check_outputs("timeout", 2'b00, 2'b01, 4'b0010);
      clr_fault = 2'b01;
      @(negedge clk);
      clr_fault = 2'b00;
      check_outputs("timeout_clr", 2'b00, 2'b00, 4'b0000);
      @(negedge clk);
      check_outputs("refill", 2'b01, 2'b00, 4'b0000);
`else
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k >= 2 && (valve !== 2'b01 || fault !== 2'b00 || fault_code !== 4'b0000)) bad++;
      end
      check("no_timeout_bad_cycles", bad, 32'd0);
      check_outputs("no_timeout_end", 2'b01, 2'b00, 4'b0000);
`endif

      // Asynchronous reset in the middle of a fill.
      lvl = 6'b111_000;
      repeat (3) @(negedge clk);
      check("fill_before_reset", 32'(valve), 32'b01);
      #2 reset = 1'b1;
      #1 check_outputs("async_reset", 2'b00, 2'b00, 4'b0000);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("after_release_edge1", 32'(valve), 32'b00);
      @(negedge clk);
      check("after_release_edge2", 32'(valve), 32'b01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_tank_level_ctrl
